// File: rtl/alu_ctl_pkg.sv
// Shared constants and types for the EX-stage ALU control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctl_pkg;

  // Instruction funct field encodings
  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] SLT   = 6'b101010;
  // Mult/div unit command that writes the HI/LO pair
  localparam logic [5:0] HILO  = 6'b111111;
  localparam logic [5:0] MD_IDLE = 6'b000000;

  // ALU operation codes
  localparam logic [2:0] ALU_and   = 3'b000;
  localparam logic [2:0] ALU_or    = 3'b001;
  localparam logic [2:0] ALU_add   = 3'b010;
  localparam logic [2:0] ALU_srl   = 3'b011;
  localparam logic [2:0] ALU_multu = 3'b100;
  localparam logic [2:0] ALU_divu  = 3'b101;
  localparam logic [2:0] ALU_sub   = 3'b110;
  localparam logic [2:0] ALU_slt   = 3'b111;

  // Result mux selects
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;

  // ALUOp class driven by main control
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    COMMIT = 2'b10
  } md_state_t;

endpackage

// File: rtl/alu_ctl_md_seq.sv
// Multicycle MULTU/DIVU sequencer: captures the op, iterates DATA_W cycles, strobes HI/LO write.
// Latency: RUN for DATA_W cycles after the issue edge, then one COMMIT cycle.
// Backpressure: requests are only accepted in IDLE; requests while busy are dropped.
module md_seq
  import alu_ctl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic [5:0]       i_funct,
  output logic [5:0]       o_md_op,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy,
  output logic             o_hilo_write,
  output logic             o_run,
  output logic             o_idle
);

  // The counter must reach DATA_W-1 without wrapping.
  if ((1 << CNT_W) <= DATA_W) begin : g_cnt_chk
    $error("md_seq: CNT_W is too narrow for DATA_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [5:0]       r_op;
  logic [5:0]       w_op_nxt;
  logic             r_busy;
  logic             r_hilo_write;
  logic [5:0]       w_md_op;

  // State, counter, captured op; busy and write strobe registered from next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_op         <= MD_IDLE;
      r_busy       <= 1'b0;
      r_hilo_write <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_op         <= w_op_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_hilo_write <= (w_state_nxt == COMMIT);
    end
  end

  // Next-state, counter and mult/div command decode
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_md_op     = MD_IDLE;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
          w_op_nxt    = i_funct;
        end
      end
      RUN: begin
        w_md_op = r_op;
        if (r_count == LAST) begin
          w_state_nxt = COMMIT;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      COMMIT: begin
        w_md_op     = HILO;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_md_op      = w_md_op;
  assign o_count      = r_count;
  assign o_busy       = r_busy;
  assign o_hilo_write = r_hilo_write;
  assign o_run        = (r_state == RUN);
  assign o_idle       = (r_state == IDLE);

endmodule

// File: rtl/alu_ctl_md.sv
// EX-stage ALU control: ALUOp/Funct decode plus MULTU/DIVU sequencing and pipeline stall.
// Latency: decode is combinational; HI/LO write strobe DATA_W+1 cycles after issue.
// Backpressure: Stall freezes IF/ID/EX while an op runs or a HI/LO read would race it.
module alu_ctl_md
  import alu_ctl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6,
  parameter bit EN_DIV = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic             Start,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       Sel,
  output logic [5:0]       MDOperation,
  output logic [CNT_W-1:0] MDCount,
  output logic             MDBusy,
  output logic             HiLoWrite,
  output logic             Stall,
  output logic             IllegalOp
);

  logic w_rtype;
  logic w_md_req;
  logic w_hilo_rd;
  logic w_run;
  logic w_idle;

  assign w_rtype   = (ALUOp == ALUOP_RTYPE);
  assign w_md_req  = Start && w_rtype &&
                     ((Funct == MULTU) || (EN_DIV && (Funct == DIVU)));
  assign w_hilo_rd = w_rtype && ((Funct == MFHI) || (Funct == MFLO));

  // ALU op code, result select and illegal-op flag from ALUOp/Funct
  always_comb begin
    ALUOperation = ALU_add;
    Sel          = SEL_ALU;
    IllegalOp    = 1'b0;
    case (ALUOp)
      2'b00: ALUOperation = ALU_add;
      2'b01: ALUOperation = ALU_sub;
      2'b10: begin
        case (Funct)
          ADD:   ALUOperation = ALU_add;
          SUB:   ALUOperation = ALU_sub;
          AND:   ALUOperation = ALU_and;
          OR:    ALUOperation = ALU_or;
          SLT:   ALUOperation = ALU_slt;
          SRL:   ALUOperation = ALU_srl;
          MULTU: ALUOperation = ALU_multu;
          DIVU: begin
            if (EN_DIV) ALUOperation = ALU_divu;
            else        IllegalOp    = 1'b1;
          end
          MFHI:    Sel       = SEL_HI;
          MFLO:    Sel       = SEL_LO;
          default: IllegalOp = 1'b1;
        endcase
      end
      default: IllegalOp = 1'b1;
    endcase
  end

  md_seq #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_req        (w_md_req),
    .i_funct      (Funct),
    .o_md_op      (MDOperation),
    .o_count      (MDCount),
    .o_busy       (MDBusy),
    .o_hilo_write (HiLoWrite),
    .o_run        (w_run),
    .o_idle       (w_idle)
  );

  // The HI/LO hazard term also covers COMMIT: HI/LO only updates at the end of that cycle.
  assign Stall = w_run || (w_idle && w_md_req) || (w_hilo_rd && MDBusy);

endmodule

// File: tb/tb_alu_ctl_md.sv
module tb_alu_ctl_md;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Start_nd = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] Funct = 6'b000000;

  logic [2:0] ALUOperation, ALUOperation_nd;
  logic [1:0] Sel, Sel_nd;
  logic [5:0] MDOperation, MDOperation_nd;
  logic [5:0] MDCount, MDCount_nd;
  logic       MDBusy, MDBusy_nd, HiLoWrite, HiLoWrite_nd;
  logic       Stall, Stall_nd, IllegalOp, IllegalOp_nd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sb_q[$];          // expected HiLoWrite cycles
  logic [5:0] dec_q[$]; // expected {ALUOperation, Sel, IllegalOp}

  alu_ctl_md #(.DATA_W(32), .CNT_W(6), .EN_DIV(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct), .Start(Start),
    .ALUOperation(ALUOperation), .Sel(Sel), .MDOperation(MDOperation),
    .MDCount(MDCount), .MDBusy(MDBusy), .HiLoWrite(HiLoWrite),
    .Stall(Stall), .IllegalOp(IllegalOp)
  );

  alu_ctl_md #(.DATA_W(32), .CNT_W(6), .EN_DIV(1'b0)) dut_nd (
    .Clk(Clk), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct), .Start(Start_nd),
    .ALUOperation(ALUOperation_nd), .Sel(Sel_nd), .MDOperation(MDOperation_nd),
    .MDCount(MDCount_nd), .MDBusy(MDBusy_nd), .HiLoWrite(HiLoWrite_nd),
    .Stall(Stall_nd), .IllegalOp(IllegalOp_nd)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard: every HiLoWrite pulse must match the oldest outstanding issue
  always @(negedge Clk) begin
    if (HiLoWrite === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL hilo_unexpected cycle=%0d got HiLoWrite=1 required 0", cyc);
      end else begin
        int e;
        e = sb_q.pop_front();
        if (cyc != e || MDOperation !== 6'b111111) begin
          errors++;
          $display("FAIL hilo_commit cycle=%0d op=%b required cycle=%0d op=111111",
                   cyc, MDOperation, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; ALUOp = 2'b10; Funct = 6'b011001;
    repeat (3) tick();
    checks++;
    if (MDBusy !== 1'b0 || MDOperation !== 6'b000000 || MDCount !== 6'd0 || HiLoWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b op=%b cnt=%0d hlw=%b required 0/000000/0/0",
               MDBusy, MDOperation, MDCount, HiLoWrite);
    end
    Reset = 1'b0; Start = 1'b0; Funct = 6'b100010;
    #1;
    checks++;
    if (ALUOperation !== 3'b110 || Sel !== 2'b00 || IllegalOp !== 1'b0 ||
        MDBusy !== 1'b0 || MDOperation !== 6'b000000) begin
      errors++;
      $display("FAIL reset_sub op=%b sel=%b ill=%b busy=%b mdop=%b required 110/00/0/0/000000",
               ALUOperation, Sel, IllegalOp, MDBusy, MDOperation);
    end
    tick();
    checks++;
    if (MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_issue busy=%b required 0", MDBusy);
    end
  endtask

  // {ALUOp, Funct, ALUOperation, Sel, IllegalOp}
  logic [13:0] dec_vec [16] = '{
    {2'b00, 6'b100010, 3'b010, 2'b00, 1'b0},
    {2'b01, 6'b000000, 3'b110, 2'b00, 1'b0},
    {2'b10, 6'b100000, 3'b010, 2'b00, 1'b0},
    {2'b10, 6'b100010, 3'b110, 2'b00, 1'b0},
    {2'b10, 6'b100100, 3'b000, 2'b00, 1'b0},
    {2'b10, 6'b100101, 3'b001, 2'b00, 1'b0},
    {2'b10, 6'b101010, 3'b111, 2'b00, 1'b0},
    {2'b10, 6'b000010, 3'b011, 2'b00, 1'b0},
    {2'b10, 6'b011001, 3'b100, 2'b00, 1'b0},
    {2'b10, 6'b011011, 3'b101, 2'b00, 1'b0},
    {2'b10, 6'b010000, 3'b010, 2'b01, 1'b0},
    {2'b10, 6'b010010, 3'b010, 2'b10, 1'b0},
    {2'b10, 6'b111111, 3'b010, 2'b00, 1'b1},
    {2'b10, 6'b000000, 3'b010, 2'b00, 1'b1},
    {2'b11, 6'b100000, 3'b010, 2'b00, 1'b1},
    {2'b11, 6'b000000, 3'b010, 2'b00, 1'b1}
  };

  task automatic test_decode();
    Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [13:0] v;
      logic [5:0]  e;
      v = dec_vec[i];
      ALUOp = v[13:12]; Funct = v[11:6];
      dec_q.push_back(v[5:0]);
      #1;
      e = dec_q.pop_front();
      checks++;
      if ({ALUOperation, Sel, IllegalOp} !== e) begin
        errors++;
        $display("FAIL decode[%0d] aluop=%b funct=%b got op/sel/ill=%b required %b",
                 i, ALUOp, Funct, {ALUOperation, Sel, IllegalOp}, e);
      end
    end
    tick();
  endtask

  task automatic test_md_issue(input logic [5:0] f);
    int c;
    Start = 1'b1; ALUOp = 2'b10; Funct = f;
    #1;
    checks++;
    if (Stall !== 1'b1 || MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL md_issue f=%b stall=%b busy=%b required 1/0", f, Stall, MDBusy);
    end
    c = cyc;
    sb_q.push_back(c + 33);
    tick();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (MDOperation !== f || MDCount !== 6'(k) || Stall !== 1'b1 || MDBusy !== 1'b1) begin
        errors++;
        $display("FAIL md_run k=%0d op=%b cnt=%0d stall=%b busy=%b required op=%b cnt=%0d 1/1",
                 k, MDOperation, MDCount, Stall, MDBusy, f, k);
      end
      tick();
    end
    checks++;
    if (MDOperation !== 6'b111111 || HiLoWrite !== 1'b1 || Stall !== 1'b0 || MDBusy !== 1'b1) begin
      errors++;
      $display("FAIL md_commit op=%b hlw=%b stall=%b busy=%b required 111111/1/0/1",
               MDOperation, HiLoWrite, Stall, MDBusy);
    end
    Funct = 6'b100000;
    tick();
    checks++;
    if (MDBusy !== 1'b0 || MDOperation !== 6'b000000 || HiLoWrite !== 1'b0 ||
        Stall !== 1'b0 || MDCount !== 6'd0) begin
      errors++;
      $display("FAIL md_idle busy=%b op=%b hlw=%b stall=%b cnt=%0d required 0/000000/0/0/0",
               MDBusy, MDOperation, HiLoWrite, Stall, MDCount);
    end
    Start = 1'b0;
  endtask

  task automatic test_div_disabled();
    int seen;
    Start = 1'b0; Start_nd = 1'b1; ALUOp = 2'b10; Funct = 6'b011011;
    #1;
    checks++;
    if (IllegalOp_nd !== 1'b1 || ALUOperation_nd !== 3'b010 || Stall_nd !== 1'b0) begin
      errors++;
      $display("FAIL nodiv_decode ill=%b op=%b stall=%b required 1/010/0",
               IllegalOp_nd, ALUOperation_nd, Stall_nd);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MDBusy_nd !== 1'b0 || HiLoWrite_nd !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL nodiv_issue busy/hlw active cycles=%0d required 0", seen);
    end
    Start_nd = 1'b0;
  endtask

  task automatic test_hazard();
    int c;
    Start = 1'b1; ALUOp = 2'b10; Funct = 6'b011001;
    #1;
    c = cyc;
    sb_q.push_back(c + 33);
    repeat (4) tick();
    Funct = 6'b010010;
    #1;
    checks++;
    if (Stall !== 1'b1 || Sel !== 2'b10 || MDOperation !== 6'b011001 || MDBusy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_busy stall=%b sel=%b op=%b busy=%b required 1/10/011001/1",
               Stall, Sel, MDOperation, MDBusy);
    end
    Start = 1'b0; ALUOp = 2'b00;
    for (int i = 0; i < 60 && MDBusy !== 1'b0; i++) tick();
    checks++;
    if (MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL hazard_timeout busy=%b required 0", MDBusy);
    end
    ALUOp = 2'b10; Funct = 6'b010010;
    #1;
    checks++;
    if (Stall !== 1'b0 || Sel !== 2'b10) begin
      errors++;
      $display("FAIL hazard_after stall=%b sel=%b required 0/10", Stall, Sel);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    Start = 1'b1; ALUOp = 2'b10; Funct = 6'b011001;
    #1;
    tick();
    Start = 1'b0; ALUOp = 2'b00;
    repeat (15) tick();
    checks++;
    if (MDCount !== 6'd15 || MDBusy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre cnt=%0d busy=%b required 15/1", MDCount, MDBusy);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (MDBusy !== 1'b0 || MDOperation !== 6'b000000 || MDCount !== 6'd0 ||
        HiLoWrite !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_state busy=%b op=%b cnt=%0d hlw=%b stall=%b required 0/000000/0/0/0",
               MDBusy, MDOperation, MDCount, HiLoWrite, Stall);
    end
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (HiLoWrite !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_hlw pulses=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    Start = 1'b1; ALUOp = 2'b10; Funct = 6'b011001;
    #1;
    c = cyc;
    sb_q.push_back(c + 33);
    repeat (33) tick();
    checks++;
    if (HiLoWrite !== 1'b1 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_commit hlw=%b stall=%b required 1/0", HiLoWrite, Stall);
    end
    tick();
    checks++;
    if (Stall !== 1'b1 || MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reissue stall=%b busy=%b required 1/0", Stall, MDBusy);
    end
    c = cyc;
    sb_q.push_back(c + 33);
    tick();
    checks++;
    if (MDBusy !== 1'b1 || MDCount !== 6'd0 || MDOperation !== 6'b011001) begin
      errors++;
      $display("FAIL b2b_run busy=%b cnt=%0d op=%b required 1/0/011001",
               MDBusy, MDCount, MDOperation);
    end
    Start = 1'b0; ALUOp = 2'b00;
    for (int i = 0; i < 60 && MDBusy !== 1'b0; i++) tick();
    checks++;
    if (MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_timeout busy=%b required 0", MDBusy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_md_issue(6'b011001);
    test_md_issue(6'b011011);
    test_div_disabled();
    test_hazard();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending outstanding=%0d required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctl_md.md
Name: alu_ctl_md

Overview:
- Next-generation ALU control unit for the pipelined MIPS datapath.
- Combinationally decodes ALUOp/Funct into the ALU operation code and the HI/LO result-select.
- Adds a parametrised multicycle sequencer for MULTU and DIVU, with an explicit start/busy handshake, a HI/LO commit strobe and a pipeline stall output.
- Sits in the EX stage, beside the ALU and the multiply/divide unit.

Parameters:
- DATA_W, 32, operand width; the sequencer runs DATA_W iteration cycles.
- CNT_W, 6, counter width; must satisfy 2**CNT_W > DATA_W.
- EN_DIV, 1, 1 enables DIVU sequencing; 0 decodes DIVU as illegal.

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- ALUOp  in  2  main-control ALU op class.
- Funct  in  6  instruction funct field.
- Start  in  1  EX-stage instruction valid; qualifies a MULTU/DIVU issue.
- ALUOperation  out  3  ALU op code.
- Sel  out  2  result mux: 00 ALU, 01 HI, 10 LO.
- MDOperation  out  6  command to the mult/div unit: MULTU, DIVU, HILO or 000000 (idle).
- MDCount  out  CNT_W  current iteration index.
- MDBusy  out  1  sequencer active (RUN or COMMIT).
- HiLoWrite  out  1  one-cycle HI/LO register write strobe.
- Stall  out  1  freeze IF/ID/EX stages.
- IllegalOp  out  1  undefined ALUOp/Funct combination.

Behaviour:
- Clocking: single clock Clk; Reset is synchronous and active-high.
- Reset: all registered state is cleared.
  - state=IDLE, MDCount=0, captured op=000000.
  - MDOperation=000000, MDBusy=0, HiLoWrite=0.
  - Reset dominates Start in the same cycle.
  - Reset during RUN/COMMIT aborts the operation with no HiLoWrite.
- Decode (combinational, independent of sequencer state):
  - ALUOp 00 -> 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 10 -> by Funct:
    - ADD 100000 -> 010; SUB 100010 -> 110; AND 100100 -> 000; OR 100101 -> 001; SLT 101010 -> 111; SRL 000010 -> 011.
    - MULTU 011001 -> 100; DIVU 011011 -> 101.
    - MFHI 010000 -> Sel=01; MFLO 010010 -> Sel=10.
  - Sel=00 in all other cases.
  - Any other combination (including ALUOp 11) -> ALUOperation=010, IllegalOp=1. No x outputs.
- Issue condition: Start=1, ALUOp=10, Funct in {MULTU, DIVU (only if EN_DIV)}, state=IDLE.
- Sequencer states: IDLE, RUN, COMMIT.
  - IDLE:
    - On issue: capture Funct, MDCount<=0, go RUN.
    - Otherwise stay in IDLE; MDOperation=000000.
  - RUN:
    - MDOperation=captured op; MDCount increments by 1 each cycle.
    - When MDCount==DATA_W-1, go COMMIT and set MDCount<=0.
  - COMMIT (exactly one cycle):
    - MDOperation=HILO (111111), HiLoWrite=1, then go IDLE.
- Latency: issue on edge 0; RUN occupies edges 1..DATA_W; COMMIT follows.
  - HiLoWrite is high during cycle DATA_W+1 after issue (33 for DATA_W=32).
  - A back-to-back issue is accepted at the earliest in the cycle after COMMIT.
- MDBusy is registered: high in RUN and COMMIT.
- Stall (combinational) = (state==RUN) OR (state==IDLE AND issue).
  - The issuing instruction is held in EX until the result commits.
  - Additional stall when MFHI/MFLO decodes while MDBusy=1 (HI/LO hazard).
  - Stall is low during COMMIT so the pipeline resumes.
- Start while busy: ignored; no new capture. The captured op is immune to Funct changes during RUN.
- MDCount never exceeds DATA_W-1. No wrap is possible because 2**CNT_W > DATA_W; an elaboration-time check enforces this.

Decomposition:
- Package alu_ctl_pkg holds:
  - funct constants (SRL, MFHI, MFLO, MULTU, DIVU, ADD, SUB, AND, OR, SLT, HILO);
  - ALU op constants (ALU_add … ALU_divu);
  - Sel encodings;
  - md_state_t enum {IDLE, RUN, COMMIT}.
- Sub-module md_seq contains the FSM, counter, captured op, MDBusy and HiLoWrite.
- The top level holds the combinational decode and the Stall/IllegalOp logic.

Test Plan:
- Reset held 3 cycles, then ALUOp=10, Funct=100010 -> ALUOperation=110, Sel=00, MDBusy=0, MDOperation=000000, IllegalOp=0.
- DATA_W=32, Start=1 with MULTU -> Stall high for 33 cycles (issue cycle plus 32 RUN cycles); MDOperation=011001; MDCount sequences 0..31; in cycle 33 after issue, MDOperation=111111, HiLoWrite=1, Stall=0; then IDLE.
- DIVU issued with EN_DIV=1 -> identical timing with MDOperation=011011. With EN_DIV=0 -> IllegalOp=1 and no issue.
- MFLO (Funct=010010) presented while MDBusy=1 -> Stall=1. After COMMIT -> Stall=0, Sel=10.
- Reset asserted at MDCount=15 of a MULTU -> next cycle state=IDLE, MDBusy=0, HiLoWrite never pulses.
- Second MULTU with Start=1 during RUN -> ignored; exactly one HiLoWrite. Issue in the cycle after COMMIT -> accepted; next HiLoWrite 33 cycles later.
